hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Parametrised forwarding and hazard unit for the RISC-V core. It generalises stage-2 forwarding from a single s3 source to NUM_FWD_STAGES downstream stages.
- Keeps a registered history of in-flight destination writers: valid, rd, and result kind.
- Picks the youngest matching producer for rs1 and rs2 of the instruction in s2.
- Asserts a load-use stall when load data is not yet forwardable, and handles redirect flushes.

Parameters:
NUM_FWD_STAGES, 2, number of history entries downstream of s2 (entry 0 = stage immediately after s2); range 1..8
LOAD_LATENCY, 1, load data is forwardable from entry index >= LOAD_LATENCY-1; range 1..NUM_FWD_STAGES
SW, max(1,$clog2(NUM_FWD_STAGES)), derived localparam; width of stage index outputs

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
instruction_s2  in  32  instruction currently in s2
valid_s2  in  1  s2 holds a real instruction
flush  in  1  branch/jump redirect; kills the s2 instruction this cycle
stall  out  1  hold s1/s2 and insert a bubble downstream
fwd_hit_1  out  1  rs1 forwarded
fwd_stage_1  out  SW  history index supplying rs1
fwd_kind_1  out  2  result kind for rs1: 0 ALU, 1 load data, 2 PC+4, 3 reserved
fwd_hit_2  out  1  rs2 forwarded
fwd_stage_2  out  SW  history index supplying rs2
fwd_kind_2  out  2  result kind for rs2, same encoding

Behaviour:
- Decode of s2:
  - rd is written by R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR, CSR.
  - rs1 is used by R, I-ALU, LOAD, STORE, BRANCH, JALR, and register-form CSR (func3[2]=0).
  - rs2 is used by R, STORE, BRANCH.
- Kind of a writer:
  - LOAD gives 1.
  - JAL and JALR give 2.
  - All other writers give 0.
- A writer with rd=x0 is recorded as invalid.
- History is entry[0..NUM_FWD_STAGES-1] of {v, rd[4:0], kind[1:0]}. It updates every cycle on posedge clk:
  - When stall=0: entry[0] <= {valid_s2 & ~flush & writes_rd & rd!=0, rd, kind}.
  - When stall=1: entry[0] <= bubble (v=0).
  - In both cases entry[i] <= entry[i-1] for i>=1. Older stages always advance.
- Reset (rst_n=0 at posedge): all entries v=0. Consequently stall=0 and all fwd_hit=0 from the next cycle; fwd_stage and fwd_kind are 0 when the hit is 0.
- Matching, done separately for each source s:
  - A candidate entry needs v=1, rd==rs_s, and source s is used by the s2 instruction.
  - The lowest index (youngest) wins.
  - Outputs are combinational from history plus instruction_s2 in the same cycle (zero latency).
- Load-use stall:
  - stall = valid_s2 & ~flush & (any used source whose winning entry has kind=1 and index < LOAD_LATENCY-1).
  - While stall is high, fwd_hit for that source stays 0.
  - Stall lasts LOAD_LATENCY-1-index cycles; it clears automatically as the load advances.
  - With LOAD_LATENCY=1, stall is never asserted.
- Simultaneous events:
  - flush dominates stall: a killed s2 neither stalls nor enters history.
  - A winning entry that is non-load suppresses an older load match, so no stall results.
- Reset mid-stall: history clears, so stall deasserts the cycle after reset.
- A match only at indices >= NUM_FWD_STAGES means no hit; the regfile supplies the value, because writeback occurs at or before that point.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - Adds outputs stall_count[31:0] and fwd_count[31:0].
  - stall_count increments each cycle stall=1.
  - fwd_count increments by the number of hits (0, 1 or 2) each cycle stall=0.
  - Both counters wrap at 2^32 and reset to 0 on rst_n=0.
- When undefined: the ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared opcode/func3 header (existing `OPC_*/`FNC_* defines) plus new constants FWD_KIND_ALU=2'd0, FWD_KIND_MEM=2'd1, FWD_KIND_PC4=2'd2.
- One combinational sub-module, hazard_decode: instruction in; rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, kind out.

Test Plan (NUM_FWD_STAGES=3, LOAD_LATENCY=2):
- addi x5,x0,1 then add x6,x5,x5 -> fwd_hit_1=fwd_hit_2=1, stage 0, kind 0, stall=0.
- lw x7,0(x1) then add x8,x7,x2 -> stall=1 for exactly 1 cycle, then fwd_hit_1=1, stage 1, kind 1.
- addi x9,x0,1; addi x9,x0,2; sub x3,x9,x9 -> stage 0 selected (youngest) on both sources.
- jal x1,+8 then jalr x0,0(x1) -> fwd_hit_1=1, stage 0, kind 2; fwd_hit_2=0.
- addi x0,x0,5 then add x4,x0,x0 -> no hits; lw x7 in s2 with flush=1, then add x8,x7,x7 -> no hit, no stall.
- rst_n=0 while stall=1 -> stall=0 and all hits 0 the next cycle; with HAZARD_PERF_EN, stall_count reads 0.

Source files
------------

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared opcode/func3 constants, forwarding result kinds and the history entry type
// used by the hazard/forwarding unit and its decoder.
package hazard_fwd_unit_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_IALU   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // func3 of ECALL/EBREAK/xRET; every other SYSTEM func3 is a CSR access
   localparam logic [2:0] FNC_PRIV   = 3'b000;

   localparam logic [1:0] FWD_KIND_ALU = 2'd0;
   localparam logic [1:0] FWD_KIND_MEM = 2'd1;
   localparam logic [1:0] FWD_KIND_PC4 = 2'd2;

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic [1:0] kind;
   } hist_entry_t;

endpackage

// File: rtl/hazard_fwd_unit_decode.sv
// Combinational decode of the s2 instruction: register indices, which of them are
// really used or written, and the kind of result the instruction produces.
module hazard_decode
   import hazard_fwd_unit_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [4:0]  rd_o,
   output logic        uses_rs1_o,
   output logic        uses_rs2_o,
   output logic        writes_rd_o,
   output logic [1:0]  kind_o
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic       unused_funct7;

   assign opc           = instr_i[6:0];
   assign f3            = instr_i[14:12];
   assign rd_o          = instr_i[11:7];
   assign rs1_o         = instr_i[19:15];
   assign rs2_o         = instr_i[24:20];
   assign unused_funct7 = ^instr_i[31:25];

   always_comb begin
      uses_rs1_o  = 1'b0;
      uses_rs2_o  = 1'b0;
      writes_rd_o = 1'b0;
      kind_o      = FWD_KIND_ALU;
      case (opc)
         OPC_R: begin
            uses_rs1_o  = 1'b1;
            uses_rs2_o  = 1'b1;
            writes_rd_o = 1'b1;
         end
         OPC_IALU: begin
            uses_rs1_o  = 1'b1;
            writes_rd_o = 1'b1;
         end
         OPC_LOAD: begin
            uses_rs1_o  = 1'b1;
            writes_rd_o = 1'b1;
            kind_o      = FWD_KIND_MEM;
         end
         OPC_STORE, OPC_BRANCH: begin
            uses_rs1_o = 1'b1;
            uses_rs2_o = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: writes_rd_o = 1'b1;
         OPC_JAL: begin
            writes_rd_o = 1'b1;
            kind_o      = FWD_KIND_PC4;
         end
         OPC_JALR: begin
            uses_rs1_o  = 1'b1;
            writes_rd_o = 1'b1;
            kind_o      = FWD_KIND_PC4;
         end
         OPC_SYSTEM: begin
            // immediate-form CSR ops (func3[2]=1) carry a zimm in the rs1 field
            if (f3 != FNC_PRIV) begin
               writes_rd_o = 1'b1;
               uses_rs1_o  = ~f3[2];
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Forwarding/hazard unit: tracks in-flight writers downstream of s2, picks the youngest
// producer per source and raises a load-use stall. Optional counters: HAZARD_PERF_EN.
module hazard_fwd_unit
   import hazard_fwd_unit_pkg::*;
#(
   parameter int NUM_FWD_STAGES = 2,
   parameter int LOAD_LATENCY   = 1,
   localparam int SW = (NUM_FWD_STAGES > 1) ? $clog2(NUM_FWD_STAGES) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   instruction_s2,
   input  logic          valid_s2,
   input  logic          flush,
   output logic          stall,
   output logic          fwd_hit_1,
   output logic [SW-1:0] fwd_stage_1,
   output logic [1:0]    fwd_kind_1,
   output logic          fwd_hit_2,
   output logic [SW-1:0] fwd_stage_2,
   output logic [1:0]    fwd_kind_2
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]   stall_count,
   output logic [31:0]   fwd_count
`endif
);

   logic [4:0]  rs1, rs2, rd;
   logic        uses_rs1, uses_rs2, writes_rd;
   logic [1:0]  kind;

   hazard_decode u_decode (
      .instr_i     (instruction_s2),
      .rs1_o       (rs1),
      .rs2_o       (rs2),
      .rd_o        (rd),
      .uses_rs1_o  (uses_rs1),
      .uses_rs2_o  (uses_rs2),
      .writes_rd_o (writes_rd),
      .kind_o      (kind)
   );

   hist_entry_t hist_q [NUM_FWD_STAGES];
   hist_entry_t hist_d [NUM_FWD_STAGES];

   logic          match1, match2, early1, early2, wait1, wait2;
   logic [SW-1:0] idx1, idx2;
   logic [1:0]    mkind1, mkind2;

   // Walk oldest to youngest so the lowest matching index is the one that sticks.
   always_comb begin
      match1 = 1'b0; idx1 = '0; mkind1 = FWD_KIND_ALU; early1 = 1'b0;
      match2 = 1'b0; idx2 = '0; mkind2 = FWD_KIND_ALU; early2 = 1'b0;
      for (int i = NUM_FWD_STAGES - 1; i >= 0; i--) begin
         if (uses_rs1 && hist_q[i].v && hist_q[i].rd == rs1) begin
            match1 = 1'b1;
            idx1   = SW'(i);
            mkind1 = hist_q[i].kind;
            early1 = (i < LOAD_LATENCY - 1);
         end
         if (uses_rs2 && hist_q[i].v && hist_q[i].rd == rs2) begin
            match2 = 1'b1;
            idx2   = SW'(i);
            mkind2 = hist_q[i].kind;
            early2 = (i < LOAD_LATENCY - 1);
         end
      end
   end

   assign wait1 = match1 && mkind1 == FWD_KIND_MEM && early1;
   assign wait2 = match2 && mkind2 == FWD_KIND_MEM && early2;
   assign stall = valid_s2 & ~flush & (wait1 | wait2);

   assign fwd_hit_1   = match1 & ~wait1;
   assign fwd_stage_1 = fwd_hit_1 ? idx1 : '0;
   assign fwd_kind_1  = fwd_hit_1 ? mkind1 : FWD_KIND_ALU;
   assign fwd_hit_2   = match2 & ~wait2;
   assign fwd_stage_2 = fwd_hit_2 ? idx2 : '0;
   assign fwd_kind_2  = fwd_hit_2 ? mkind2 : FWD_KIND_ALU;

   // A stalled s2 leaves a bubble behind it; older entries always move on.
   always_comb begin
      hist_d[0].v    = ~stall & valid_s2 & ~flush & writes_rd & (rd != 5'd0);
      hist_d[0].rd   = rd;
      hist_d[0].kind = kind;
      for (int i = 1; i < NUM_FWD_STAGES; i++) hist_d[i] = hist_q[i-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_FWD_STAGES; i++) hist_q[i] <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_count_q, stall_count_d;
   logic [31:0] fwd_count_q, fwd_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      fwd_count_d   = fwd_count_q;
      if (stall) stall_count_d = stall_count_q + 32'd1;
      else       fwd_count_d   = fwd_count_q + 32'(fwd_hit_1) + 32'(fwd_hit_2);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_count_q <= '0;
         fwd_count_q   <= '0;
      end else begin
         stall_count_q <= stall_count_d;
         fwd_count_q   <= fwd_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign fwd_count   = fwd_count_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit (NUM_FWD_STAGES=3, LOAD_LATENCY=2): directed table of
// per-cycle vectors, then random traffic against a queue-based reference model.
module tb_hazard_fwd_unit;

   localparam int N  = 3;
   localparam int LL = 2;

   localparam bit [6:0] O_LOAD = 7'h03, O_IALU = 7'h13, O_AUIPC = 7'h17, O_STORE = 7'h23,
                        O_R = 7'h33, O_LUI = 7'h37, O_BR = 7'h63, O_JALR = 7'h67,
                        O_JAL = 7'h6f, O_SYS = 7'h73;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        valid, flush;
   logic        stall, hit1, hit2;
   logic [1:0]  stg1, stg2, knd1, knd2;
`ifdef HAZARD_PERF_EN
   logic [31:0] sc, fc;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_fwd_unit #(.NUM_FWD_STAGES(N), .LOAD_LATENCY(LL)) dut (
      .clk(clk), .rst_n(rst_n), .instruction_s2(instr), .valid_s2(valid), .flush(flush),
      .stall(stall),
      .fwd_hit_1(hit1), .fwd_stage_1(stg1), .fwd_kind_1(knd1),
      .fwd_hit_2(hit2), .fwd_stage_2(stg2), .fwd_kind_2(knd2)
`ifdef HAZARD_PERF_EN
      , .stall_count(sc), .fwd_count(fc)
`endif
   );

   function automatic bit [31:0] enc_r(bit [6:0] f7, bit [4:0] rs2, bit [4:0] rs1, bit [4:0] rd);
      return {f7, rs2, rs1, 3'b000, rd, O_R};
   endfunction
   function automatic bit [31:0] enc_i(bit [11:0] imm, bit [4:0] rs1, bit [2:0] f3, bit [4:0] rd, bit [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic bit [31:0] enc_jal(bit [20:0] imm, bit [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, O_JAL};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic [31:0] ins, logic v, logic fl, logic rn);
      @(negedge clk);
      instr = ins; valid = v; flush = fl; rst_n = rn;
      #1;
   endtask

   // ---------------- reference model: youngest-first list of recent writers
   typedef struct { bit v; bit [4:0] rd; bit [1:0] kind; } ent_t;
   ent_t hist[$];
   bit        m_stall, m_h1, m_h2;
   bit [1:0]  m_s1, m_s2, m_k1, m_k2;
   bit [31:0] m_sc, m_fc;

   function automatic void ref_decode(bit [31:0] ins, output bit u1, output bit u2,
                                      output bit wr, output bit [1:0] kd);
      bit [6:0] op = ins[6:0];
      bit [2:0] f3 = ins[14:12];
      bit csr = (op == O_SYS) && (f3 != 3'b000);
      u1 = (op inside {O_R, O_IALU, O_LOAD, O_STORE, O_BR, O_JALR}) || (csr && !f3[2]);
      u2 = op inside {O_R, O_STORE, O_BR};
      wr = (op inside {O_R, O_IALU, O_LOAD, O_LUI, O_AUIPC, O_JAL, O_JALR}) || csr;
      kd = (op == O_LOAD) ? 2'd1 : (op inside {O_JAL, O_JALR}) ? 2'd2 : 2'd0;
   endfunction

   function automatic void ref_source(bit used, bit [4:0] rs, output bit hit,
                                      output bit [1:0] stg, output bit [1:0] kd, output bit w);
      hit = 0; stg = 0; kd = 0; w = 0;
      if (!used) return;
      for (int j = 0; j < hist.size(); j++) begin
         if (hist[j].v && hist[j].rd == rs) begin
            if (hist[j].kind == 2'd1 && j < LL - 1) w = 1;
            else begin hit = 1; stg = 2'(j); kd = hist[j].kind; end
            return;
         end
      end
   endfunction

   task automatic model_eval();
      bit u1, u2, wr, w1, w2;
      bit [1:0] kd;
      ref_decode(instr, u1, u2, wr, kd);
      ref_source(u1, instr[19:15], m_h1, m_s1, m_k1, w1);
      ref_source(u2, instr[24:20], m_h2, m_s2, m_k2, w2);
      m_stall = valid && !flush && (w1 || w2);
   endtask

   task automatic model_clock();
      bit u1, u2, wr;
      bit [1:0] kd;
      ent_t e;
      if (!rst_n) begin
         foreach (hist[j]) hist[j].v = 0;
         m_sc = 0; m_fc = 0;
         return;
      end
      if (m_stall) m_sc++;
      else m_fc += 32'(m_h1) + 32'(m_h2);
      ref_decode(instr, u1, u2, wr, kd);
      e.v = !m_stall && valid && !flush && wr && instr[11:7] != 0;
      e.rd = instr[11:7];
      e.kind = kd;
      hist.push_front(e);
      void'(hist.pop_back());
   endtask

   // ---------------- directed vectors
   typedef struct {
      bit [31:0] ins; bit v; bit fl; bit rn;
      bit st; bit h1; bit [1:0] s1; bit [1:0] k1; bit h2; bit [1:0] s2; bit [1:0] k2;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(bit [31:0] ins, bit v, bit fl, bit rn, bit st,
                               bit h1, bit [1:0] s1, bit [1:0] k1,
                               bit h2, bit [1:0] s2, bit [1:0] k2);
      vec_t r;
      r.ins = ins; r.v = v; r.fl = fl; r.rn = rn; r.st = st;
      r.h1 = h1; r.s1 = s1; r.k1 = k1; r.h2 = h2; r.s2 = s2; r.k2 = k2;
      return r;
   endfunction

   initial begin
      bit [31:0] nop, addi5, add6, lw7, add8, addi9a, addi9b, sub3, jal1, jalr0, addi0, add4,
                 add8b, addi7, add8c, addi10, add11a, add11b, cur;
      nop    = enc_i(12'd0, 5'd0, 3'd0, 5'd0, O_IALU);
      addi5  = enc_i(12'd1, 5'd0, 3'd0, 5'd5, O_IALU);
      add6   = enc_r(7'h00, 5'd5, 5'd5, 5'd6);
      lw7    = enc_i(12'd0, 5'd1, 3'd2, 5'd7, O_LOAD);
      add8   = enc_r(7'h00, 5'd2, 5'd7, 5'd8);
      addi9a = enc_i(12'd1, 5'd0, 3'd0, 5'd9, O_IALU);
      addi9b = enc_i(12'd2, 5'd0, 3'd0, 5'd9, O_IALU);
      sub3   = enc_r(7'h20, 5'd9, 5'd9, 5'd3);
      jal1   = enc_jal(21'd8, 5'd1);
      jalr0  = enc_i(12'd0, 5'd1, 3'd0, 5'd0, O_JALR);
      addi0  = enc_i(12'd5, 5'd0, 3'd0, 5'd0, O_IALU);
      add4   = enc_r(7'h00, 5'd0, 5'd0, 5'd4);
      add8b  = enc_r(7'h00, 5'd7, 5'd7, 5'd8);
      addi7  = enc_i(12'd1, 5'd0, 3'd0, 5'd7, O_IALU);
      add8c  = enc_r(7'h00, 5'd0, 5'd7, 5'd8);
      addi10 = enc_i(12'd1, 5'd0, 3'd0, 5'd10, O_IALU);
      add11a = enc_r(7'h00, 5'd0, 5'd10, 5'd11);
      add11b = enc_r(7'h00, 5'd10, 5'd10, 5'd11);

      //                ins     v  fl rn  st h1 s1 k1 h2 s2 k2
      tbl.push_back(mk(nop,    0, 0, 1,  0, 0, 0, 0, 0, 0, 0)); // reset state
      tbl.push_back(mk(addi5,  1, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(add6,   1, 0, 1,  0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(lw7,    1, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(add8,   1, 0, 1,  1, 0, 0, 0, 0, 0, 0)); // load-use
      tbl.push_back(mk(add8,   1, 0, 1,  0, 1, 1, 1, 0, 0, 0)); // load now forwardable
      tbl.push_back(mk(addi9a, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(addi9b, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(sub3,   1, 0, 1,  0, 1, 0, 0, 1, 0, 0)); // youngest x9
      tbl.push_back(mk(jal1,   1, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(jalr0,  1, 0, 1,  0, 1, 0, 2, 0, 0, 0)); // PC+4 kind
      tbl.push_back(mk(addi0,  1, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(add4,   1, 0, 1,  0, 0, 0, 0, 0, 0, 0)); // x0 never recorded
      tbl.push_back(mk(lw7,    1, 1, 1,  0, 0, 0, 0, 0, 0, 0)); // flushed load
      tbl.push_back(mk(add8b,  1, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(lw7,    1, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(add8b,  1, 0, 0,  1, 0, 0, 0, 0, 0, 0)); // reset while stalled
      tbl.push_back(mk(add8b,  1, 0, 1,  0, 0, 0, 0, 0, 0, 0)); // history cleared
      tbl.push_back(mk(lw7,    1, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(addi7,  1, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(add8c,  1, 0, 1,  0, 1, 0, 0, 0, 0, 0)); // ALU shadows older load
      tbl.push_back(mk(addi10, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(nop,    0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(nop,    0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(add11a, 1, 0, 1,  0, 1, 2, 0, 0, 0, 0)); // oldest entry
      tbl.push_back(mk(add11b, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0)); // aged out

      instr = nop; valid = 0; flush = 0; rst_n = 0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         string tag;
         drive(tbl[i].ins, tbl[i].v, tbl[i].fl, tbl[i].rn);
         tag = $sformatf("vec%0d", i);
         check({tag, ".stall"},  stall, tbl[i].st);
         check({tag, ".hit1"},   hit1,  tbl[i].h1);
         check({tag, ".stage1"}, stg1,  tbl[i].s1);
         check({tag, ".kind1"},  knd1,  tbl[i].k1);
         check({tag, ".hit2"},   hit2,  tbl[i].h2);
         check({tag, ".stage2"}, stg2,  tbl[i].s2);
         check({tag, ".kind2"},  knd2,  tbl[i].k2);
`ifdef HAZARD_PERF_EN
         if (i == 17) check("stall_count_after_reset", sc, 32'd0);
`endif
      end

      // ---------------- random traffic against the model
      for (int j = 0; j < N; j++) hist.push_back('{0, 5'd0, 2'd0});
      drive(nop, 0, 0, 0);
      model_eval();
      model_clock();
      cur = nop;
      for (int c = 0; c < 600; c++) begin
         bit [6:0] ops [10] = '{O_R, O_IALU, O_LOAD, O_STORE, O_BR, O_LUI, O_AUIPC, O_JAL, O_JALR, O_SYS};
         bit v, fl, rn;
         if (!m_stall) begin
            cur = $urandom;
            cur[6:0]   = ops[$urandom_range(0, 9)];
            cur[11:7]  = 5'($urandom_range(0, 3));
            cur[19:15] = 5'($urandom_range(0, 3));
            cur[24:20] = 5'($urandom_range(0, 3));
         end
         v  = ($urandom_range(0, 7) != 0);
         fl = ($urandom_range(0, 7) == 0);
         rn = ($urandom_range(0, 99) != 0);
         drive(cur, v, fl, rn);
         model_eval();
         check("rnd.stall",  stall, m_stall);
         check("rnd.hit1",   hit1,  m_h1);
         check("rnd.stage1", stg1,  m_s1);
         check("rnd.kind1",  knd1,  m_k1);
         check("rnd.hit2",   hit2,  m_h2);
         check("rnd.stage2", stg2,  m_s2);
         check("rnd.kind2",  knd2,  m_k2);
`ifdef HAZARD_PERF_EN
         check("rnd.stall_count", sc, m_sc);
         check("rnd.fwd_count",   fc, m_fc);
`endif
         model_clock();
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
